// File: rtl/uart_ctrl_pkg.sv
// Shared types and defaults for the UART control blocks.
// Optional packet lock in the arbiter: UART_ARB_LOCK_EN.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_ACC,
    WAIT_DONE
  } arb_state_t;

  localparam int UART_DATA_W     = 8;
  localparam int DEF_ACK_TIMEOUT = 32;
  localparam int DEF_MAX_RETRY   = 3;

endpackage

// File: rtl/uart_tx_arbiter_picker.sv
// Combinational round-robin select: first request after ptr,
// with wrap-around. Module uart_rr_picker.
module uart_rr_picker #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int i = 1; i <= N; i++) begin
      j = IW'((int'(ptr) + i) % N);
      if (!any && req[j]) begin
        any    = 1'b1;
        idx    = j;
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter with launch retry.
// Define UART_ARB_LOCK_EN to keep a requester granted until req_last.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int DATA_W      = UART_DATA_W,
  parameter  int ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  parameter  int MAX_RETRY   = DEF_MAX_RETRY,
  localparam int IW          = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_wr_en,
  output logic [DATA_W-1:0]         tx_din,
  input  logic                      tx_busy,
  output logic [IW-1:0]             grant_id,
  output logic                      active,
  output logic                      err_drop
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  arb_state_t           state;
  logic [IW-1:0]        ptr;
  logic [DATA_W-1:0]    hold;
  logic [TW-1:0]        tcnt;
  logic [RW-1:0]        retry;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic [NUM_REQ-1:0]   sel_gnt;
  logic [IW-1:0]        sel_idx;
  logic                 sel_valid;
  logic [DATA_W-1:0]    sel_data;

  uart_rr_picker #(.N(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

`ifdef UART_ARB_LOCK_EN
  logic          locked;
  logic [IW-1:0] lock_id;

  // A locked packet owner is the only legal grant.
  always_comb begin
    sel_gnt   = pick_gnt;
    sel_idx   = pick_idx;
    sel_valid = pick_any;
    if (locked) begin
      sel_gnt   = NUM_REQ'(1) << lock_id;
      sel_idx   = lock_id;
      sel_valid = req_valid[lock_id];
    end
  end
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign sel_gnt     = pick_gnt;
  assign sel_idx     = pick_idx;
  assign sel_valid   = pick_any;
`endif

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (sel_idx == IW'(i))
        sel_data = req_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= '0;
      tx_wr_en  <= 1'b0;
      tx_din    <= '0;
      grant_id  <= '0;
      active    <= 1'b0;
      err_drop  <= 1'b0;
      ptr       <= IW'(NUM_REQ - 1);
      hold      <= '0;
      tcnt      <= '0;
      retry     <= '0;
`ifdef UART_ARB_LOCK_EN
      locked    <= 1'b0;
      lock_id   <= '0;
`endif
    end else begin
      req_ready <= '0;
      tx_wr_en  <= 1'b0;
      err_drop  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!tx_busy && sel_valid) begin
            req_ready <= sel_gnt;
            hold      <= sel_data;
            grant_id  <= sel_idx;
            retry     <= '0;
            active    <= 1'b1;
            state     <= LAUNCH;
`ifdef UART_ARB_LOCK_EN
            locked    <= ~req_last[sel_idx];
            lock_id   <= sel_idx;
`endif
          end
        end
        LAUNCH: begin
          tx_wr_en <= 1'b1;
          tx_din   <= hold;
          tcnt     <= '0;
          state    <= WAIT_ACC;
        end
        WAIT_ACC: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (tcnt == TW'(ACK_TIMEOUT - 1)) begin
            if (retry == RW'(MAX_RETRY)) begin
              err_drop <= 1'b1;
              active   <= 1'b0;
              ptr      <= grant_id;
              state    <= IDLE;
`ifdef UART_ARB_LOCK_EN
              locked   <= 1'b0;
`endif
            end else begin
              retry <= retry + 1'b1;
              state <= LAUNCH;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            active <= 1'b0;
            state  <= IDLE;
`ifdef UART_ARB_LOCK_EN
            if (!locked)
              ptr <= grant_id;
`else
            ptr    <= grant_id;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed corner cases,
// and random traffic against a round-robin reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  typedef struct {
    logic [N-1:0]  vld;
    int            exp_g;
    logic [DW-1:0] exp_d;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            tx_wr_en;
  logic [DW-1:0]   tx_din;
  logic            tx_busy;
  logic [1:0]      grant_id;
  logic            active;
  logic            err_drop;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_W(DW), .ACK_TIMEOUT(32), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready),
    .tx_wr_en(tx_wr_en), .tx_din(tx_din), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active), .err_drop(err_drop)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // transmitter model
  int acc_dly = 2;
  int blen    = 10;
  int acc_cnt = 0;
  int bcnt    = 0;
  bit dead    = 0;
  bit force_busy = 0;
  bit busy_m  = 0;

  // scoreboard
  int            last_g  = N - 1;
  int            want_wr = -1;
  int            drop_cyc = -1;
  int            n_drop  = 0;
  bit            sb_rr   = 1;
  logic [DW-1:0] exp_din = '0;
  int            gq[$];
  int            dq[$];
  int            wq[$];

  task automatic chk(input bit ok, input string name,
                     input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cycle);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int i = 1; i <= N; i++)
      if (v[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  task automatic step();
    logic [N-1:0]    v_s;
    logic [N*DW-1:0] d_s;
    logic            b_s;
    logic            r_s;
    int              g;
    int              e;
    v_s = req_valid;
    d_s = req_data;
    b_s = tx_busy;
    r_s = rst;
    @(posedge clk);
    #1;
    cycle++;
    if (r_s) begin
      last_g  = N - 1;
      want_wr = -1;
      busy_m  = 0;
      acc_cnt = 0;
      bcnt    = 0;
    end else begin
      if (req_ready != '0) begin
        g = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        chk($onehot(req_ready), "ready_onehot", int'(req_ready), 1);
        e = rr_pick(v_s, last_g);
        if (sb_rr) chk(g == e, "rr_order", g, e);
        chk(v_s[g] && !b_s, "grant_legal", int'(v_s), int'(b_s));
        chk(int'(grant_id) == g, "grant_id", int'(grant_id), g);
        exp_din = d_s[g*DW +: DW];
        want_wr = cycle + 1;
        last_g  = g;
        gq.push_back(g);
      end
      if (cycle == want_wr)
        chk(tx_wr_en == 1'b1, "launch_latency", int'(tx_wr_en), 1);
      if (tx_wr_en) begin
        chk(tx_din == exp_din, "launch_data", int'(tx_din), int'(exp_din));
        dq.push_back(int'(tx_din));
        wq.push_back(cycle);
      end
      if (err_drop) begin
        n_drop++;
        drop_cyc = cycle;
      end
      if (busy_m) begin
        bcnt--;
        if (bcnt <= 0) busy_m = 0;
      end else if (acc_cnt > 0) begin
        acc_cnt--;
        if (acc_cnt == 0) begin
          busy_m = 1;
          bcnt   = blen;
        end
      end else if (tx_wr_en && !dead) begin
        acc_cnt = acc_dly;
      end
    end
    tx_busy = busy_m | force_busy;
  endtask

  task automatic wait_ready(output int g, input int budget,
                            input string name);
    g = -1;
    for (int c = 0; c < budget && g < 0; c++) begin
      step();
      for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
    end
    if (g < 0) chk(1'b0, name, -1, 0);
  endtask

  task automatic wait_wr(input int budget, input string name);
    bit seen;
    seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      step();
      seen = tx_wr_en;
    end
    if (!seen) chk(1'b0, name, 0, 1);
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      step();
      done = !active && !tx_busy;
    end
    if (!done) chk(1'b0, "idle_timeout", int'(active), 0);
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk(req_ready == '0, {tag, "_ready"}, int'(req_ready), 0);
    chk(!tx_wr_en, {tag, "_wr_en"}, int'(tx_wr_en), 0);
    chk(tx_din == '0, {tag, "_din"}, int'(tx_din), 0);
    chk(grant_id == '0, {tag, "_grant"}, int'(grant_id), 0);
    chk(!active, {tag, "_active"}, int'(active), 0);
    chk(!err_drop, {tag, "_drop"}, int'(err_drop), 0);
  endtask

  vec_t tbl[6];

  initial begin
    int            g;
    int            k;
    bit            saw;
    logic [N-1:0]  pend;
    logic [DW-1:0] b;

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '1;
    tx_busy   = 1'b0;
    step();
    rst = 1'b0;
    chk_reset("por");

    // grant from reset under different valid patterns
    tbl[0] = '{4'b0001, 0, 8'hA0};
    tbl[1] = '{4'b0010, 1, 8'hB1};
    tbl[2] = '{4'b1100, 2, 8'hC2};
    tbl[3] = '{4'b1000, 3, 8'hD3};
    tbl[4] = '{4'b1111, 0, 8'hA0};
    tbl[5] = '{4'b1010, 1, 8'hB1};
    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    for (int t = 0; t < 6; t++) begin
      do_reset();
      req_valid = tbl[t].vld;
      wait_ready(g, 6, "tbl_ready_timeout");
      req_valid = '0;
      chk(g == tbl[t].exp_g, "tbl_grant", g, tbl[t].exp_g);
      wait_wr(4, "tbl_wr_timeout");
      chk(tx_din == tbl[t].exp_d, "tbl_din",
          int'(tx_din), int'(tbl[t].exp_d));
      wait_idle(40);
    end

    // single requester, full handshake
    do_reset();
    req_data[7:0] = 8'hA5;
    req_valid = 4'b0001;
    wait_ready(g, 4, "single_ready_timeout");
    k = cycle;
    req_valid = '0;
    wait_wr(3, "single_wr_timeout");
    chk(cycle == k + 1, "single_wr_cycle", cycle - k, 1);
    chk(tx_din == 8'hA5, "single_din", int'(tx_din), 'hA5);
    for (int c = 0; c < 10 && !tx_busy; c++) step();
    for (int c = 0; c < 20 && tx_busy; c++) step();
    chk(active, "single_active_hold", int'(active), 1);
    step();
    chk(!active, "single_active_low", int'(active), 0);

    // four requesters contending continuously
    do_reset();
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req_valid = 4'hF;
    gq.delete();
    dq.delete();
    for (int c = 0; c < 200 && dq.size() < 5; c++) step();
    req_valid = '0;
    chk(dq.size() == 5, "rr4_count", dq.size(), 5);
    if (dq.size() == 5 && gq.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk(gq[i] == i % 4, "rr4_grant", gq[i], i % 4);
        chk(dq[i] == 'h11 * (i % 4 + 1), "rr4_din", dq[i],
            'h11 * (i % 4 + 1));
      end
    end
    wait_idle(60);

    // transmitter never accepts: retries then drop
    do_reset();
    dead = 1;
    req_data = {8'h44, 8'h33, 8'h5A, 8'hC3};
    req_valid = 4'b0011;
    wait_ready(g, 4, "dead_ready_timeout");
    chk(g == 0, "dead_first", g, 0);
    req_valid = 4'b0010;
    wq.delete();
    n_drop = 0;
    for (int c = 0; c < 200 && n_drop == 0; c++) step();
    chk(n_drop == 1, "dead_drop", n_drop, 1);
    chk(wq.size() == 4, "dead_launches", wq.size(), 4);
    if (wq.size() == 4) begin
      for (int i = 1; i < 4; i++)
        chk(wq[i] - wq[i-1] == 33, "dead_spacing", wq[i] - wq[i-1], 33);
      chk(drop_cyc == wq[3] + 32, "dead_drop_cycle",
          drop_cyc - wq[3], 32);
    end
    k = cycle;
    wait_ready(g, 4, "dead_next_timeout");
    chk(g == 1, "dead_next_grant", g, 1);
    chk(cycle == k + 1, "dead_next_cycle", cycle - k, 1);
    req_valid = '0;
    dead = 0;

    // external busy blocks arbitration
    do_reset();
    force_busy = 1;
    tx_busy = 1'b1;
    req_valid = 4'b0010;
    saw = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (req_ready != '0) saw = 1;
    end
    chk(!saw, "busy_block", int'(saw), 0);
    force_busy = 0;
    tx_busy = busy_m;
    step();
    chk(req_ready == 4'b0010, "busy_release", int'(req_ready), 2);
    req_valid = '0;
    wait_idle(40);

    // reset in WAIT_DONE
    do_reset();
    req_valid = 4'b0100;
    wait_ready(g, 4, "rst_ready_timeout");
    chk(g == 2, "rst_first", g, 2);
    req_valid = '0;
    for (int c = 0; c < 10 && !tx_busy; c++) step();
    step();
    chk(active, "rst_in_flight", int'(active), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("midrst");
    req_valid = 4'b0101;
    wait_ready(g, 4, "rst_next_timeout");
    chk(g == 0, "rst_ptr", g, 0);
    req_valid = '0;
    wait_idle(40);

    // random traffic against the reference model
    do_reset();
    gq.delete();
    dq.delete();
    n_drop = 0;
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      acc_dly = $urandom_range(1, 3);
      blen    = $urandom_range(1, 12);
      step();
      pend = pend & ~req_ready;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 7) == 0) begin
          b = DW'($urandom);
          req_data[i*DW +: DW] = b;
          pend[i] = 1'b1;
        end
      end
      req_valid = pend;
    end
    req_valid = '0;
    wait_idle(100);
    chk(n_drop == 0, "rand_no_drop", n_drop, 0);
    chk(gq.size() == dq.size(), "rand_launch_count", dq.size(), gq.size());
    chk(gq.size() > 20, "rand_progress", gq.size(), 21);

`ifdef UART_ARB_LOCK_EN
    // packet lock keeps requester 1 until its last byte
    do_reset();
    sb_rr = 0;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req_last = 4'b1101;
    req_valid = 4'b0010;
    wait_ready(g, 4, "lock_ready_timeout");
    chk(g == 1, "lock_b0", g, 1);
    req_valid = 4'b0011;
    wait_ready(g, 40, "lock_ready_timeout");
    chk(g == 1, "lock_b1", g, 1);
    req_last = 4'b1111;
    wait_ready(g, 40, "lock_ready_timeout");
    chk(g == 1, "lock_b2", g, 1);
    req_valid = 4'b0001;
    wait_ready(g, 40, "lock_ready_timeout");
    chk(g == 0, "lock_release", g, 0);
    req_valid = '0;
    wait_idle(40);
    sb_rr = 1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
